// File: rtl/weight_prefetch.sv
// rtl/weight_prefetch.sv - weight tile prefetcher: SRAM words into a staging tile, ping-pong handoff to the PE delay line
module weight_prefetch #(
  parameter int N      = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 8,
  parameter int ADDR_W = 12,
  parameter int TILE_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [TILE_W-1:0]      num_tiles,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [N-1:0]           mem_rdata,
  input  logic                   mem_rvalid,
  input  logic                   tile_ready,
  output logic                   w_en,
  output logic                   buf_select,
  output logic [ROWS*COLS*N-1:0] weight_bus,
  output logic                   busy,
  output logic                   done
);
  localparam int T     = ROWS * COLS;
  localparam int CNT_W = $clog2(T + 1);
  localparam int IDX_W = (T > 1) ? $clog2(T) : 1;
  localparam logic [CNT_W-1:0]  T_CNT   = CNT_W'(T);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [TILE_W:0]   TL_ONE  = (TILE_W+1)'(1);
  localparam logic [TILE_W-1:0] TW_ONE  = TILE_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, FINISH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [TILE_W-1:0]   num_q, num_d;
  logic [TILE_W-1:0]   fetched_q, fetched_d;
  logic [TILE_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]    req_q, req_d;
  logic [CNT_W-1:0]    rcv_q, rcv_d;
  logic                full_q, full_d;
  logic                bsel_q, bsel_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [N-1:0]        staging_q [T];
  logic [T*N-1:0]      bus_q;

  logic                wen_c, accept_c, xfer_c, capture_c, issue_c, last_c;
  logic [ADDR_W-1:0]   tile_off_c;

  always_comb begin
    wen_c      = full_q & tile_ready;
    accept_c   = start & (state_q == IDLE) & ~busy_q;
    // A staged tile may move out when the output slot is empty or is being consumed this cycle.
    xfer_c     = (state_q == HOLD) & (~full_q | wen_c);
    capture_c  = (state_q == LOAD) & mem_rvalid & (rcv_q < T_CNT);
    issue_c    = (state_q == LOAD) & (req_q < T_CNT);
    last_c     = (state_q == FINISH) & wen_c;
    tile_off_c = ADDR_W'(fetched_q) * ADDR_W'(T);
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    fetched_d = fetched_q;
    sent_d    = sent_q;
    req_d     = req_q;
    rcv_d     = rcv_q;
    full_d    = full_q;
    bsel_d    = bsel_q;
    case (state_q)
      IDLE: begin
        if (accept_c && (num_tiles != '0)) begin
          state_d   = LOAD;
          base_d    = base_addr;
          num_d     = num_tiles;
          fetched_d = '0;
          sent_d    = '0;
          req_d     = '0;
          rcv_d     = '0;
        end
      end
      LOAD: begin
        if (issue_c)   req_d = req_q + CNT_ONE;
        if (capture_c) rcv_d = rcv_q + CNT_ONE;
        if (capture_c && (rcv_q == T_CNT - CNT_ONE)) state_d = HOLD;
      end
      HOLD: begin
        if (xfer_c) begin
          fetched_d = fetched_q + TW_ONE;
          req_d     = '0;
          rcv_d     = '0;
          state_d   = (({1'b0, fetched_q} + TL_ONE) < {1'b0, num_q}) ? LOAD : FINISH;
        end
      end
      FINISH: begin
        if (last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wen_c) begin
      bsel_d = ~bsel_q;
      sent_d = sent_q + TW_ONE;
      full_d = 1'b0;
    end
    if (xfer_c) full_d = 1'b1;
    done_d = last_c | (accept_c & (num_tiles == '0));
    busy_d = (state_d != IDLE) | last_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      fetched_q <= '0;
      sent_q    <= '0;
      req_q     <= '0;
      rcv_q     <= '0;
      full_q    <= 1'b0;
      bsel_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      fetched_q <= fetched_d;
      sent_q    <= sent_d;
      req_q     <= req_d;
      rcv_q     <= rcv_d;
      full_q    <= full_d;
      bsel_q    <= bsel_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < T; k++) staging_q[k] <= '0;
      bus_q <= '0;
    end else begin
      if (capture_c) staging_q[rcv_q[IDX_W-1:0]] <= mem_rdata;
      if (xfer_c) begin
        for (int k = 0; k < T; k++) bus_q[k*N +: N] <= staging_q[k];
      end
    end
  end

  assign mem_req    = issue_c;
  assign mem_addr   = base_q + tile_off_c + ADDR_W'(req_q);
  assign w_en       = wen_c;
  assign buf_select = bsel_q;
  assign weight_bus = bus_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_weight_prefetch.sv
// tb/tb_weight_prefetch.sv - scoreboard bench for weight_prefetch: directed jobs, queued addresses/tiles/done checked by a monitor
module tb_weight_prefetch;
  localparam int N = 8, ROWS = 4, COLS = 8, ADDR_W = 12, TILE_W = 8;
  localparam int T = ROWS * COLS, BW = T * N;

  typedef struct packed {
    logic [BW-1:0] bus;
    logic          bsel;
  } tile_t;

  logic              clk = 1'b0;
  logic              reset_n, start, tile_ready, mem_rvalid;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [TILE_W-1:0] num_tiles;
  logic [N-1:0]      mem_rdata;
  logic              mem_req, w_en, buf_select, busy, done;
  logic [BW-1:0]     weight_bus;

  int compared = 0, mismatched = 0;
  int req_seen = 0, wen_seen = 0, done_seen = 0;
  int stray_req = 0, stray_ack = 0;
  bit mon_en = 0, prev_wen = 0, prev_start = 0, exp_bsel = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  tile_t             exp_tile_q[$];
  bit                exp_done_q[$];

  weight_prefetch #(.N(N), .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .tile_ready(tile_ready), .w_en(w_en), .buf_select(buf_select), .weight_bus(weight_bus),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event present, none expected", name);
  endtask

  // SRAM: 1-cycle latency, rdata = addr[7:0]; stray responses injected on request
  initial begin
    logic              pv;
    logic [ADDR_W-1:0] pa;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      pv = mem_req;
      pa = mem_addr;
      @(posedge clk);
      #1;
      if (stray_ack < stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hEE;
        stray_ack++;
      end else begin
        mem_rvalid = pv;
        mem_rdata  = pa[7:0];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req) begin
        req_seen++;
        if (exp_addr_q.size() == 0) flag("extra_req");
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (w_en) begin
        wen_seen++;
        if (exp_tile_q.size() == 0) flag("extra_w_en");
        else begin
          tile_t t;
          t = exp_tile_q.pop_front();
          check("weight_bus", weight_bus, t.bus);
          check("buf_select", buf_select, t.bsel);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done_q.size() == 0) flag("extra_done");
        else begin
          check("busy_in_done", busy, exp_done_q.pop_front());
          check("done_timing", prev_wen | prev_start, 1);
        end
      end
    end
    prev_wen   = w_en;
    prev_start = start;
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_job(logic [ADDR_W-1:0] b, int n);
    tile_t             t;
    logic [ADDR_W-1:0] a;
    for (int ti = 0; ti < n; ti++) begin
      t = '0;
      for (int k = 0; k < T; k++) begin
        a = b + ADDR_W'(ti * T + k);
        exp_addr_q.push_back(a);
        t.bus[k*N +: N] = a[7:0];
      end
      t.bsel   = exp_bsel;
      exp_bsel = ~exp_bsel;
      exp_tile_q.push_back(t);
    end
    exp_done_q.push_back(n != 0);
  endtask

  task automatic pulse_start(logic [ADDR_W-1:0] b, logic [TILE_W-1:0] n);
    start     = 1'b1;
    base_addr = b;
    num_tiles = n;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0 = done_seen;
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (done_seen != d0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag("done_timeout");
    else check("busy_after_done", busy, 0);
    check("addr_q_drained", exp_addr_q.size(), 0);
    check("tile_q_drained", exp_tile_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_w_en"}, w_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_buf_select"}, buf_select, 0);
    check({tag, "_weight_bus"}, weight_bus, 0);
  endtask

  initial begin
    int r0, w0, d0;
    reset_n = 1'b0; start = 1'b0; tile_ready = 1'b0; base_addr = '0; num_tiles = '0;
    cyc(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    mon_en  = 1;
    cyc(2);

    // single tile, 1-cycle SRAM
    tile_ready = 1'b1;
    push_job(12'h010, 1);
    pulse_start(12'h010, 8'd1);
    check("busy_after_start", busy, 1);
    wait_done(200);

    // three tiles with consumer stalled until two tiles are fetched
    tile_ready = 1'b0;
    push_job(12'h010, 3);
    r0 = req_seen; w0 = wen_seen;
    pulse_start(12'h010, 8'd3);
    cyc(150);
    check("stalled_req_count", req_seen - r0, 64);
    check("stalled_w_en_count", wen_seen - w0, 0);
    tile_ready = 1'b1;
    wait_done(300);
    check("three_tile_w_en_count", wen_seen - w0, 3);

    // address wrap
    push_job(12'hFF0, 1);
    pulse_start(12'hFF0, 8'd1);
    wait_done(200);

    // zero-tile job
    r0 = req_seen; w0 = wen_seen;
    push_job(12'h123, 0);
    pulse_start(12'h123, 8'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    cyc(1);
    check("zero_done_cleared", done, 0);
    check("zero_busy_after", busy, 0);
    cyc(5);
    check("zero_req_count", req_seen - r0, 0);
    check("zero_w_en_count", wen_seen - w0, 0);

    // start while busy is ignored
    r0 = req_seen; d0 = done_seen;
    push_job(12'h200, 2);
    pulse_start(12'h200, 8'd2);
    cyc(10);
    pulse_start(12'h300, 8'd5);
    wait_done(300);
    cyc(20);
    check("busy_start_req_count", req_seen - r0, 64);
    check("busy_start_done_count", done_seen - d0, 1);

    // reset mid-load with stray responses afterwards
    push_job(12'h100, 1);
    pulse_start(12'h100, 8'd1);
    cyc(11);
    mon_en  = 0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_addr_q.delete();
    exp_tile_q.delete();
    exp_done_q.delete();
    exp_bsel = 0;
    cyc(3);
    reset_n = 1'b1;
    stray_req = stray_req + 3;
    cyc(6);
    check_reset_outputs("after_stray");
    mon_en = 1;
    push_job(12'h020, 1);
    pulse_start(12'h020, 8'd1);
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/weight_prefetch.md
Name: weight_prefetch

Overview:
- Fetches 4x8 PE weight tiles from on-chip weight SRAM, one N-bit word per read, and assembles each tile in a 32-lane staging register.
- Presents each completed tile on a 32-lane output bus and pulses w_en so the downstream 3-stage weight delay line captures it in one cycle.
- Overlaps fetch of tile t+1 with holding of tile t, so the PE array sees one new tile per w_en with no fetch gap once primed.

Parameters:
- N, 8, weight word width in bits
- ROWS, 4, PE rows per tile
- COLS, 8, PE columns per tile; tile size T = ROWS*COLS = 32
- ADDR_W, 12, SRAM word-address width
- TILE_W, 8, width of the tile-count input

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a job; ignored while busy=1
- base_addr  in  ADDR_W  word address of lane 0 of tile 0; sampled on an accepted start
- num_tiles  in  TILE_W  tiles in the job; sampled on an accepted start
- mem_req  out  1  read request, one word per cycle
- mem_addr  out  ADDR_W  read address, valid when mem_req=1
- mem_rdata  in  N  read data
- mem_rvalid  in  1  mem_rdata valid; responses return in request order
- tile_ready  in  1  consumer can accept a tile this cycle
- w_en  out  1  tile transfer strobe to the weight delay line
- buf_select  out  1  ping-pong tag of the tile on weight_bus
- weight_bus  out  T*N  lane k at [k*N +: N]; lane k feeds PE row k/COLS+1, column k%COLS+1
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the last tile transfers

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, all counters=0, staging=0, weight_bus=0, out_full=0, buf_select=0, mem_req=0, busy=0, done=0. w_en=0 because out_full=0. Reset mid-job aborts the job; outstanding SRAM responses arriving after release are ignored because rcv_cnt is only advanced in LOAD.
- FSM states:
  - IDLE -> LOAD on start when num_tiles!=0. Latch base_addr and num_tiles; tiles_fetched=0, tiles_sent=0.
  - IDLE with start and num_tiles=0: done pulses on the next cycle, busy stays 0, no mem_req.
  - LOAD -> HOLD when rcv_cnt reaches T (staging full).
  - HOLD -> LOAD or FINISH when staging moves into the output register.
  - FINISH -> IDLE on the w_en of the last tile.
- Request issue (LOAD only): mem_req=1 while req_cnt<T.
  - mem_addr = base_addr + tiles_fetched*T + req_cnt, modulo 2^ADDR_W (wraps).
  - req_cnt increments each issued cycle. This gives one request per cycle, up to T outstanding.
- Response: on mem_rvalid in LOAD with rcv_cnt<T, staging[rcv_cnt]<=mem_rdata and rcv_cnt++. mem_rvalid in any other state, or with rcv_cnt=T, is ignored.
- Staging to output transfer: occurs in the cycle where staging is full and (out_full=0 or w_en=1).
  - weight_bus<=staging, out_full<=1, tiles_fetched++.
  - req_cnt and rcv_cnt clear to 0.
  - Next state: LOAD if tiles_fetched+1<num_tiles, else FINISH.
- w_en = out_full & tile_ready (combinational). On each w_en cycle: buf_select toggles, tiles_sent++, and out_full clears unless a transfer happens in the same cycle.
  - Back-to-back w_en on consecutive cycles is legal when staging refills in time.
  - weight_bus is stable whenever out_full=1 and w_en=0.
- done = registered pulse, 1 cycle after the w_en that makes tiles_sent=num_tiles.
- busy = 1 from the cycle after an accepted start until the cycle done is asserted, inclusive of the done cycle; busy=0 the cycle after done.
- Staging fill is independent of tile_ready; fetch stalls only by withholding requests once req_cnt=T.

Test Plan:
- Reset, then start with base_addr=0x010, num_tiles=1; SRAM returns rdata=addr[7:0] with 1-cycle latency; tile_ready=1 -> mem_addr 0x010..0x02F on 32 consecutive cycles; one w_en; lane k = 0x10+k; buf_select 0->1; done 1 cycle after w_en.
- num_tiles=3, tile_ready held 0 until staging holds tile 1 -> w_en stays 0; exactly 64 requests are issued and no more. Then tile_ready=1 -> tiles 0,1,2 transfer with w_en in order; buf_select 1,0,1; addresses 0x010..0x06F are contiguous.
- base_addr=0xFF0, num_tiles=1 -> mem_addr runs 0xFF0..0xFFF, then wraps to 0x000..0x00F.
- start with num_tiles=0 -> done pulses next cycle; mem_req and w_en never assert; busy stays 0.
- Second start during a 2-tile job -> ignored; only 64 requests are issued; done pulses once.
- Assert reset_n=0 mid-LOAD (rcv_cnt=10), then release with 3 stray mem_rvalid -> all outputs at reset values; stray data is not captured; a new start with num_tiles=1 completes normally.
